mac_learn_table: RTL and testbench

MAC_LEARN_TABLE -- requirements
Module: mac_learn_table

---
 rtl/mac_learn_table.sv | 231 +++++++++++++++++++++++
 tb/tb_mac_learn_table.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_learn_table.sv
// Learning MAC table: captures DA/SA, scans the table one entry per cycle, learns the SA, reports forwarding.
// o_val rises pDEPTH+2 cycles after byte 11 is sampled; frames arriving while busy are dropped (no backpressure).
module mac_learn_table #(
  parameter int pPORT_N = 4,
  parameter int pDEPTH  = 16,
  parameter int pAGE_W  = 4,
  localparam int pPORT_W = (pPORT_N > 1) ? $clog2(pPORT_N) : 1,
  localparam int pIDX_W  = (pDEPTH > 1) ? $clog2(pDEPTH) : 1
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic               i_dv,
  input  logic [7:0]         irx_d,
  input  logic [pPORT_W-1:0] i_port_num,
  input  logic               i_age_tick,
  input  logic               i_flush,
  output logic               o_val,
  output logic [pPORT_W-1:0] o_port_num,
  output logic               o_flood,
  output logic               o_drop,
  output logic               o_full,
  output logic               o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SEARCH, S_LEARN, S_RESULT} state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_dv_d;
  logic [3:0]          r_byte_cnt;
  logic [95:0]         r_addr;
  logic [pPORT_W-1:0]  r_in_port;
  logic [pIDX_W-1:0]   r_idx;
  logic                r_da_hit;
  logic [pPORT_W-1:0]  r_da_port;
  logic                r_sa_hit;
  logic [pIDX_W-1:0]   r_sa_idx;
  logic                r_free_hit;
  logic [pIDX_W-1:0]   r_free_idx;

  logic                r_val;
  logic [pPORT_W-1:0]  r_port_out;
  logic                r_flood;
  logic                r_drop;

  logic                r_vld  [pDEPTH];
  logic [47:0]         r_mac  [pDEPTH];
  logic [pPORT_W-1:0]  r_port [pDEPTH];
  logic [pAGE_W-1:0]   r_age  [pDEPTH];

  logic [47:0]         w_da;
  logic [47:0]         w_sa;
  logic                w_start;
  logic                w_last_idx;
  logic                w_learn_wr;
  logic [pIDX_W-1:0]   w_learn_idx;
  logic                w_flood;
  logic                w_drop;
  logic [pPORT_W-1:0]  w_port;

  assign w_da       = r_addr[95:48];
  assign w_sa       = r_addr[47:0];
  // Only a fresh rising edge of i_dv in IDLE opens a frame.
  assign w_start    = i_dv & ~r_dv_d;
  assign w_last_idx = (r_idx == pIDX_W'(pDEPTH - 1));

  assign w_flood = w_da[40] | ~r_da_hit;
  assign w_drop  = ~w_flood & (r_da_port == r_in_port);
  assign w_port  = w_flood ? '0 : r_da_port;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_full      = 1'b0;
    w_learn_wr  = 1'b0;
    w_learn_idx = r_free_idx;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!i_dv) begin
          w_next = S_IDLE;
        end else if (r_byte_cnt == 4'd11) begin
          w_next = S_SEARCH;
        end
      end
      S_SEARCH: begin
        o_busy = 1'b1;
        if (w_last_idx) w_next = S_LEARN;
      end
      S_LEARN: begin
        o_busy = 1'b1;
        w_next = S_RESULT;
        if (!w_sa[40]) begin
          if (r_sa_hit) begin
            w_learn_wr  = 1'b1;
            w_learn_idx = r_sa_idx;
          end else if (r_free_hit) begin
            w_learn_wr  = 1'b1;
          end else begin
            o_full      = 1'b1;
          end
        end
      end
      S_RESULT: begin
        o_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_dv_d resets high so a frame already in flight at reset release is not picked up.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_dv_d     <= 1'b1;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_in_port  <= '0;
      r_idx      <= '0;
      r_da_hit   <= 1'b0;
      r_da_port  <= '0;
      r_sa_hit   <= 1'b0;
      r_sa_idx   <= '0;
      r_free_hit <= 1'b0;
      r_free_idx <= '0;
      r_val      <= 1'b0;
      r_port_out <= '0;
      r_flood    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_dv_d <= i_dv;
      r_val  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr     <= {r_addr[87:0], irx_d};
            r_in_port  <= i_port_num;
            r_byte_cnt <= 4'd1;
          end
        end
        S_CAPTURE: begin
          if (!i_dv) begin
            r_byte_cnt <= '0;
          end else begin
            r_addr <= {r_addr[87:0], irx_d};
            if (r_byte_cnt == 4'd11) begin
              r_byte_cnt <= '0;
              r_idx      <= '0;
              r_da_hit   <= 1'b0;
              r_sa_hit   <= 1'b0;
              r_free_hit <= 1'b0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
            end
          end
        end
        S_SEARCH: begin
          // First match wins; results are latched so later aging cannot undo a hit.
          if (r_vld[r_idx]) begin
            if (!r_da_hit && (r_mac[r_idx] == w_da)) begin
              r_da_hit  <= 1'b1;
              r_da_port <= r_port[r_idx];
            end
            if (!r_sa_hit && (r_mac[r_idx] == w_sa)) begin
              r_sa_hit <= 1'b1;
              r_sa_idx <= r_idx;
            end
          end else if (!r_free_hit) begin
            r_free_hit <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (!w_last_idx) r_idx <= r_idx + 1'b1;
        end
        S_RESULT: begin
          r_val      <= 1'b1;
          r_flood    <= w_flood;
          r_drop     <= w_drop;
          r_port_out <= w_port;
        end
        default: ;
      endcase
    end
  end

  // Priority per entry: flush, then learn write, then aging.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < pDEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_mac[i]  <= '0;
        r_port[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < pDEPTH; i++) begin
        if (i_flush) begin
          r_vld[i] <= 1'b0;
          r_age[i] <= '0;
        end else if (w_learn_wr && (w_learn_idx == pIDX_W'(i))) begin
          r_vld[i]  <= 1'b1;
          r_mac[i]  <= w_sa;
          r_port[i] <= r_in_port;
          r_age[i]  <= '0;
        end else if (i_age_tick && r_vld[i]) begin
          if (r_age[i] == {pAGE_W{1'b1}}) begin
            r_vld[i] <= 1'b0;
          end else begin
            r_age[i] <= r_age[i] + 1'b1;
          end
        end
      end
    end
  end

  assign o_val      = r_val;
  assign o_port_num = r_port_out;
  assign o_flood    = r_flood;
  assign o_drop     = r_drop;

endmodule

// File: tb/tb_mac_learn_table.sv
// Directed bench for mac_learn_table: forwarding, learning, full table, aging, runts, busy frames, reset abort.
module tb_mac_learn_table;

  logic       iclk       = 1'b0;
  logic       irst_n     = 1'b0;
  logic       i_dv       = 1'b0;
  logic [7:0] irx_d      = 8'h00;
  logic [1:0] i_port_num = 2'd0;
  logic       i_age_tick = 1'b0;
  logic       i_flush    = 1'b0;
  logic       o_val;
  logic [1:0] o_port_num;
  logic       o_flood;
  logic       o_drop;
  logic       o_full;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  int         r_lat;
  int         r_nval;
  logic       r_flood;
  logic       r_drop;
  logic       r_full;
  logic       r_busy;
  logic [1:0] r_pn;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] GRPSA = 48'h0100_0000_0002;
  localparam logic [47:0] CAFE  = 48'h00CA_FE00_0001;

  always #5 iclk = ~iclk;

  mac_learn_table #(.pPORT_N(4), .pDEPTH(16), .pAGE_W(4)) dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .i_dv       (i_dv),
    .irx_d      (irx_d),
    .i_port_num (i_port_num),
    .i_age_tick (i_age_tick),
    .i_flush    (i_flush),
    .o_val      (o_val),
    .o_port_num (o_port_num),
    .o_flood    (o_flood),
    .o_drop     (o_drop),
    .o_full     (o_full),
    .o_busy     (o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends nbytes of {da,sa}, then watches 40 cycles. tick_at/rst_at/ovl_at are watch-cycle
  // numbers at which to drive an age tick, a reset pulse, or start a second (overlapping) frame.
  task automatic run_frame(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] port,
                           input int nbytes, input int tick_at, input int rst_at, input int ovl_at);
    logic [95:0] f;
    logic [95:0] ov;
    f  = {da, sa};
    ov = {BCAST, 48'h00DE_AD00_00BE};
    r_lat = 0; r_nval = 0; r_full = 1'b0; r_busy = 1'b0;
    r_flood = 1'b0; r_drop = 1'b0; r_pn = 2'd0;
    for (int b = 0; b < nbytes; b++) begin
      i_dv = 1'b1;
      irx_d = f[95-8*b -: 8];
      i_port_num = port;
      @(posedge iclk); #1;
    end
    i_dv = 1'b0;
    irx_d = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iclk); #1;
      if (o_val) begin
        r_nval++;
        if (r_lat == 0) begin
          r_lat = k; r_flood = o_flood; r_drop = o_drop; r_pn = o_port_num;
        end
      end
      if (o_full) r_full = 1'b1;
      if (k == 1) r_busy = o_busy;
      i_age_tick = (k == tick_at);
      irst_n = (k != rst_at);
      if (ovl_at > 0 && k >= ovl_at && k < ovl_at + 12) begin
        i_dv = 1'b1;
        irx_d = ov[95-8*(k-ovl_at) -: 8];
      end else begin
        i_dv = 1'b0;
        irx_d = 8'h00;
      end
    end
    i_age_tick = 1'b0;
    irst_n = 1'b1;
  endtask

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      i_age_tick = 1'b1;
      @(posedge iclk); #1;
    end
    i_age_tick = 1'b0;
  endtask

  task automatic flush();
    i_flush = 1'b1;
    @(posedge iclk); #1;
    i_flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_val",   o_val, 0);
    chk("rst_port",  o_port_num, 0);
    chk("rst_flood", o_flood, 0);
    chk("rst_drop",  o_drop, 0);
    chk("rst_full",  o_full, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_vld0",  dut.r_vld[0], 0);
    irst_n = 1'b1;
    @(posedge iclk); #1;

    // broadcast DA floods; SA learned at index 0
    run_frame(BCAST, 48'h0011_2233_4455, 2'd1, 12, 0, 0, 0);
    chk("f1_lat",   r_lat, 18);
    chk("f1_nval",  r_nval, 1);
    chk("f1_flood", r_flood, 1);
    chk("f1_port",  r_pn, 0);
    chk("f1_drop",  r_drop, 0);
    chk("f1_busy",  r_busy, 1);
    chk("f1_vld0",  dut.r_vld[0], 1);
    chk("f1_mac0",  dut.r_mac[0], 48'h0011_2233_4455);
    chk("f1_prt0",  dut.r_port[0], 1);

    // known DA forwards to port 1; SA learned at index 1
    run_frame(48'h0011_2233_4455, 48'h00AA_BBCC_DDEE, 2'd2, 12, 0, 0, 0);
    chk("f2_lat",   r_lat, 18);
    chk("f2_flood", r_flood, 0);
    chk("f2_drop",  r_drop, 0);
    chk("f2_port",  r_pn, 1);
    chk("f2_vld1",  dut.r_vld[1], 1);
    chk("f2_prt1",  dut.r_port[1], 2);

    // same DA from its own port is filtered
    run_frame(48'h0011_2233_4455, 48'h0011_2233_4455, 2'd1, 12, 0, 0, 0);
    chk("f3_drop",  r_drop, 1);
    chk("f3_flood", r_flood, 0);
    repeat (5) @(posedge iclk);
    #1;
    chk("hold_drop", o_drop, 1);
    chk("hold_val",  o_val, 0);

    // 8-byte runt
    run_frame(48'h00AA_BBCC_DDEE, 48'h0000_0000_0077, 2'd3, 8, 0, 0, 0);
    chk("runt_nval", r_nval, 0);
    chk("runt_vld2", dut.r_vld[2], 0);

    // a second frame arriving during SEARCH is ignored
    run_frame(BCAST, 48'h0000_0000_0066, 2'd0, 12, 0, 0, 3);
    chk("ovl_nval", r_nval, 1);
    chk("ovl_lat",  r_lat, 18);
    chk("ovl_vld3", dut.r_vld[3], 0);
    run_frame(48'h00DE_AD00_00BE, 48'h0000_0000_0066, 2'd0, 12, 0, 0, 0);
    chk("ovl_flood", r_flood, 1);

    // flush, then group SA is not learned
    flush();
    chk("fl_vld0", dut.r_vld[0], 0);
    run_frame(48'h0011_2233_4455, GRPSA, 2'd1, 12, 0, 0, 0);
    chk("fl_flood", r_flood, 1);
    chk("grp_vld0", dut.r_vld[0], 0);

    // fill all 16 entries, then overflow
    for (int i = 0; i < 16; i++) begin
      run_frame(BCAST, {40'h00_0000_0010, 8'(i)}, 2'(i), 12, 0, 0, 0);
    end
    chk("fill_full", r_full, 0);
    chk("fill_vld15", dut.r_vld[15], 1);
    run_frame(BCAST, 48'h0000_0000_1099, 2'd0, 12, 0, 0, 0);
    chk("ovf_full",  r_full, 1);
    chk("ovf_nval",  r_nval, 1);
    chk("ovf_mac15", dut.r_mac[15], 48'h0000_0000_100F);
    run_frame(48'h0000_0000_1099, 48'h0000_0000_1000, 2'd0, 12, 0, 0, 0);
    chk("ovf_flood", r_flood, 1);
    chk("hit_full",  r_full, 0);
    run_frame(48'h0000_0000_1005, 48'h0000_0000_1000, 2'd0, 12, 0, 0, 0);
    chk("idx5_flood", r_flood, 0);
    chk("idx5_port",  r_pn, 1);

    // aging out after 16 ticks
    flush();
    run_frame(BCAST, CAFE, 2'd3, 12, 0, 0, 0);
    tick(15);
    chk("age15_vld", dut.r_vld[0], 1);
    chk("age15_age", dut.r_age[0], 15);
    tick(1);
    chk("age16_vld", dut.r_vld[0], 0);
    run_frame(CAFE, GRPSA, 2'd0, 12, 0, 0, 0);
    chk("aged_flood", r_flood, 1);

    // refresh after tick 10 keeps the entry alive through 16 ticks
    flush();
    run_frame(BCAST, CAFE, 2'd3, 12, 0, 0, 0);
    tick(10);
    run_frame(BCAST, CAFE, 2'd3, 12, 0, 0, 0);
    tick(6);
    chk("refr_vld", dut.r_vld[0], 1);
    chk("refr_age", dut.r_age[0], 6);
    run_frame(CAFE, GRPSA, 2'd0, 12, 0, 0, 0);
    chk("refr_flood", r_flood, 0);
    chk("refr_port",  r_pn, 3);

    // age tick in the LEARN cycle on the entry being learned
    run_frame(BCAST, CAFE, 2'd3, 12, 16, 0, 0);
    chk("coin_vld", dut.r_vld[0], 1);
    chk("coin_age", dut.r_age[0], 0);
    chk("coin_flood", r_flood, 1);

    // reset pulse mid-search aborts the frame
    run_frame(BCAST, 48'h0000_0000_BEEF, 2'd2, 12, 0, 5, 0);
    chk("rsm_nval",  r_nval, 0);
    chk("rsm_vld0",  dut.r_vld[0], 0);
    chk("rsm_vld1",  dut.r_vld[1], 0);
    chk("rsm_flood", o_flood, 0);
    chk("rsm_port",  o_port_num, 0);
    chk("rsm_busy",  o_busy, 0);
    run_frame(BCAST, 48'h0000_0000_BEEF, 2'd2, 12, 0, 0, 0);
    chk("post_lat",  r_lat, 18);
    chk("post_vld0", dut.r_vld[0], 1);
    chk("post_prt0", dut.r_port[0], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
